rom_serial_reader: RTL and testbench
====================================

# rom_serial_reader

Read-side initiator for the 128 × 20-bit constant ROM. On a start command it fetches a run of consecutive ROM words through the ROM's registered read port. It shifts each word out LSB-first on the CADC serial word bus, with a valid/ready bit handshake and a word-mark on bit 19. It sits between the ROM and the serial arithmetic units and is the only master of the ROM address port.

## Interface
- WORD_W, 20, bits per ROM word and per serial word
- ADDR_W, 7, ROM address width (DEPTH = 2**ADDR_W = 128)
- clk  in  1  rising-edge clock, the only clock
- rst_n  in  1  reset, asynchronous and active-low
- start  in  1  command strobe; sampled only in IDLE
- start_addr  in  ADDR_W  first word address
- count  in  ADDR_W+1  number of words, 0..128
- abort  in  1  cancel current run
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at normal run completion
- rom_addr  out  ADDR_W  ROM read address (registered)
- rom_data  in  WORD_W  ROM read data, valid one clock after rom_addr changes
- ser_data  out  1  current serial bit
- ser_valid  out  1  ser_data is valid
- ser_ready  in  1  downstream accepts bit; transfer = ser_valid & ser_ready
- word_mark  out  1  high while ser_data is bit 19 of a word

## Operation
- States:
  - IDLE: waits for start.
  - PRIME: address issued, waiting for ROM latency.
  - SHIFT: bits flowing.
- IDLE, start=1, count≠0 → rom_addr ← start_addr, remaining ← count, busy ← 1, → PRIME.
- IDLE, start=1, count=0 → done pulses next cycle; busy stays 0.
- PRIME lasts 2 edges:
  - Edge 1: the ROM registers the data.
  - Edge 2: shift register ← rom_data, bit index ← 0, ser_valid ← 1, rom_addr ← rom_addr+1 (prefetch) → SHIFT.
- SHIFT, each transfer: shift right, index+1.
- Prefetch: one cycle after rom_addr advances, the holding buffer captures rom_data and is marked full.
- On the transfer of bit 19:
  - remaining ← remaining−1.
  - If remaining becomes 0: ser_valid ← 0, busy ← 0, done ← 1, → IDLE.
  - Otherwise: shift register ← holding buffer, buffer empty, rom_addr+1, no bubble.
- rom_addr wraps 127 → 0 (modulo 2**ADDR_W); a run of 128 words visits every address once.
- Prefetch never issues beyond the last word of the run.
- Bits 0..18 drive word_mark = 0; bit 19 drives word_mark = 1.
- start while busy is ignored, with no effect on the run.
- abort (any non-IDLE state) → next edge: IDLE, busy 0, ser_valid 0, word_mark 0, buffer empty, no done pulse. abort takes priority over a same-cycle final transfer.
- With ser_ready low, ser_data, word_mark and ser_valid hold steady. The prefetch still completes.

## Timing
- Reset values: busy 0, done 0, rom_addr 0, ser_data 0, ser_valid 0, word_mark 0, state IDLE, buffer empty.
- start accepted at edge k → bit 0 valid after edge k+2.
- With ser_ready tied high, a run of N words completes in 2 + 20N cycles; done pulses after edge k+2+20N.
- Inter-word gap is 0 cycles under continuous ready.
- done and busy fall on the same edge. A new start may be accepted on the following edge.
- Reset mid-run → all state returns to reset values immediately (asynchronous assert). Restart requires a fresh start after rst_n rises.

## Structure
- Shared package cadc_pkg holds:
  - WORD_W, ADDR_W.
  - The reader state enum (IDLE, PRIME, SHIFT).
  - A word_t typedef, shared with the ROM and the serial arithmetic units.
- One sub-module: word_shifter. It holds the 20-bit shift register and bit index, and generates word_mark. It has load/shift inputs and a last_bit output.
- Control FSM, address counter, remaining counter and holding buffer stay in the top.

## Test plan
- ROM word 5 = 20'h8_0001; start_addr 5, count 1, ready high → bits 1,0×18,1 on cycles k+2..k+21. word_mark only on the 20th bit. done at k+22, busy low the same edge.
- start_addr 127, count 2 → words 127 then 0 serialized back-to-back. rom_addr wraps to 0, no gap cycle.
- count 128 from address 0, ready high → 2560 bits, 128 word_marks, words in address order, done after edge 2+2560.
- Random ser_ready (~50% duty) on 3 words → identical bit stream to the ready-high run. Outputs stable on every stalled cycle.
- abort asserted at bit 7 of word 2 → ser_valid/busy low next edge, no done. A subsequent start of count 1 works normally.
- rst_n pulsed low mid-word → all outputs at reset values immediately. start while busy and count 0 → ignored / single done pulse with busy never high.

Source files
------------

// File: rtl/cadc_pkg.sv
// Shared CADC definitions: word/address geometry, the serial word type used by
// the constant ROM and the serial arithmetic units, and the ROM reader state set.
package cadc_pkg;

  localparam int unsigned WORD_W    = 20;
  localparam int unsigned ADDR_W    = 7;
  localparam int unsigned BIT_IDX_W = $clog2(WORD_W);

  typedef logic [WORD_W-1:0]    word_t;
  typedef logic [ADDR_W-1:0]    addr_t;
  // Word count needs one extra bit so a full 128-word sweep is expressible.
  typedef logic [ADDR_W:0]      count_t;
  typedef logic [BIT_IDX_W-1:0] bit_idx_t;

  localparam bit_idx_t LAST_BIT_IDX = bit_idx_t'(WORD_W - 1);

  typedef enum logic [1:0] {
    StIdle,
    StPrime,
    StShift
  } reader_state_e;

endpackage

// File: rtl/word_shifter.sv
// LSB-first serializer for one CADC word.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   clear       - empty the register and rewind the bit index (highest priority)
//   load        - take load_data as a fresh word, bit index back to 0
//   load_data   - word to serialize
//   shift       - advance to the next bit (ignored on the last bit)
//   ser_data    - bit currently presented
//   word_mark   - high while the presented bit is the word's MSB
//   last_bit    - same condition, for the controller
module word_shifter
  import cadc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              load,
  input  logic [WORD_W-1:0] load_data,
  input  logic              shift,
  output logic              ser_data,
  output logic              word_mark,
  output logic              last_bit
);

  word_t    sr_q, sr_d;
  bit_idx_t idx_q, idx_d;

  always_comb begin
    sr_d  = sr_q;
    idx_d = idx_q;
    if (clear) begin
      sr_d  = '0;
      idx_d = '0;
    end else if (load) begin
      sr_d  = load_data;
      idx_d = '0;
    end else if (shift && !last_bit) begin
      sr_d  = sr_q >> 1;
      idx_d = idx_q + bit_idx_t'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q  <= '0;
      idx_q <= '0;
    end else begin
      sr_q  <= sr_d;
      idx_q <= idx_d;
    end
  end

  assign ser_data  = sr_q[0];
  assign last_bit  = (idx_q == LAST_BIT_IDX);
  assign word_mark = last_bit;

endmodule

// File: rtl/rom_serial_reader.sv
// Read-side initiator for the 128 x 20-bit constant ROM. Fetches a run of
// consecutive words through the ROM's registered read port and streams them
// LSB-first over a valid/ready bit interface, marking bit 19 of every word.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   start       - command strobe, honoured only when idle
//   start_addr  - first word address
//   count       - words in the run (0..128); 0 just pulses done
//   abort       - drop the current run without a done pulse
//   busy        - run in progress
//   done        - one-cycle pulse on normal completion
//   rom_addr    - registered ROM read address
//   rom_data    - ROM read data, valid one clock after rom_addr changes
//   ser_data    - serial bit
//   ser_valid   - ser_data valid; a bit moves when ser_valid & ser_ready
//   ser_ready   - downstream accepts the bit
//   word_mark   - high while ser_data is bit 19
module rom_serial_reader
  import cadc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   count,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [WORD_W-1:0] rom_data,
  output logic              ser_data,
  output logic              ser_valid,
  input  logic              ser_ready,
  output logic              word_mark
);

  localparam count_t CntOne = count_t'(1);
  localparam count_t CntTwo = count_t'(2);

  reader_state_e state_q, state_d;
  logic          prime_q, prime_d;       // second PRIME edge pending
  addr_t         addr_q, addr_d;
  count_t        rem_q, rem_d;           // words not yet fully shifted, incl. current
  word_t         buf_q, buf_d;
  logic          buf_full_q, buf_full_d;
  logic [1:0]    pf_q, pf_d;             // prefetch in flight: [0] ROM latching, [1] data on bus
  logic          valid_q, valid_d;
  logic          done_q, done_d;

  logic  sh_clear, sh_load, sh_shift, sh_last;
  word_t sh_load_data;
  logic  advance, flush;

  always_comb begin
    state_d      = state_q;
    prime_d      = prime_q;
    addr_d       = addr_q;
    rem_d        = rem_q;
    buf_d        = buf_q;
    buf_full_d   = buf_full_q;
    valid_d      = valid_q;
    done_d       = 1'b0;
    sh_clear     = 1'b0;
    sh_load      = 1'b0;
    sh_load_data = rom_data;
    sh_shift     = 1'b0;
    advance      = 1'b0;
    flush        = 1'b0;

    // Prefetched word lands in the holding buffer regardless of stalls.
    if (pf_q[1]) begin
      buf_d      = rom_data;
      buf_full_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (count != '0) begin
            addr_d  = start_addr;
            rem_d   = count;
            prime_d = 1'b0;
            state_d = StPrime;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StPrime: begin
        if (abort) begin
          flush = 1'b1;
        end else if (!prime_q) begin
          prime_d = 1'b1;
        end else begin
          sh_load = 1'b1;
          valid_d = 1'b1;
          state_d = StShift;
          advance = (rem_q >= CntTwo);
        end
      end
      StShift: begin
        if (abort) begin
          flush = 1'b1;
        end else if (valid_q && ser_ready) begin
          if (sh_last) begin
            rem_d = rem_q - CntOne;
            if (rem_q == CntOne) begin
              sh_clear = 1'b1;
              valid_d  = 1'b0;
              done_d   = 1'b1;
              state_d  = StIdle;
            end else begin
              // Next word comes from the buffer; prefetch only if a word
              // beyond it still belongs to the run.
              sh_load      = 1'b1;
              sh_load_data = buf_q;
              buf_full_d   = 1'b0;
              advance      = (rem_q > CntTwo);
            end
          end else begin
            sh_shift = 1'b1;
          end
        end
      end
      default: flush = 1'b1;
    endcase

    // Address counter wraps modulo the ROM depth by its width.
    if (advance) begin
      addr_d = addr_q + addr_t'(1);
    end

    if (flush) begin
      state_d    = StIdle;
      prime_d    = 1'b0;
      valid_d    = 1'b0;
      buf_full_d = 1'b0;
      sh_clear   = 1'b1;
    end

    pf_d = flush ? 2'b00 : {pf_q[0], advance};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      prime_q    <= 1'b0;
      addr_q     <= '0;
      rem_q      <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      pf_q       <= 2'b00;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      prime_q    <= prime_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      pf_q       <= pf_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
    end
  end

  word_shifter u_word_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (sh_clear),
    .load      (sh_load),
    .load_data (sh_load_data),
    .shift     (sh_shift),
    .ser_data  (ser_data),
    .word_mark (word_mark),
    .last_bit  (sh_last)
  );

  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign rom_addr  = addr_q;
  assign ser_valid = valid_q;

endmodule

// File: tb/tb_rom_serial_reader.sv
// Bench for rom_serial_reader: a registered-read ROM model with random
// contents, and an expected bit stream computed directly from ROM contents
// (word at (start_addr + n/20) mod 128, bit n mod 20).
module tb_rom_serial_reader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [6:0]  start_addr;
  logic [7:0]  count;
  logic        abort;
  logic        busy;
  logic        done;
  logic [6:0]  rom_addr;
  logic [19:0] rom_data;
  logic        ser_data;
  logic        ser_valid;
  logic        ser_ready;
  logic        word_mark;

  logic [19:0] rom_mem [128];

  int n_checks = 0;
  int n_fail   = 0;

  rom_serial_reader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .count      (count),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .ser_data   (ser_data),
    .ser_valid  (ser_valid),
    .ser_ready  (ser_ready),
    .word_mark  (word_mark)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a run and follow it to completion (or to an abort point).
  // pct: ser_ready duty in percent. abort_at: transfer index at which abort
  // is raised (-1 for none). poke: fire a stray start while busy.
  task automatic run(input int addr, input int cnt, input int pct,
                     input int abort_at, input bit poke);
    int          t;
    int          nbits;
    int          first_t;
    bit          done_seen;
    logic        pv, pr, pd, pm;
    logic [19:0] w;
    logic [6:0]  a7;
    logic [7:0]  c8;
    a7 = addr[6:0];
    c8 = cnt[7:0];
    start_addr = a7;
    count      = c8;
    start      = 1'b1;
    step();
    start     = 1'b0;
    t         = 0;
    nbits     = 0;
    first_t   = -1;
    done_seen = 1'b0;
    while (!done_seen && t < 80 * cnt + 50) begin
      if (nbits == abort_at) begin
        abort     = 1'b1;
        ser_ready = 1'b1;
        step();
        abort = 1'b0;
        check("abort_valid", ser_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_mark", word_mark, 0);
        check("abort_done", done, 0);
        for (int i = 0; i < 25; i++) begin
          step();
          check("abort_no_done", {busy, done}, 0);
        end
        return;
      end
      check("busy_run", busy, 1);
      if (t == 1) check("addr_first", rom_addr, addr % 128);
      if (t == 2) check("addr_prefetch", rom_addr, (addr + (cnt > 1 ? 1 : 0)) % 128);
      if (ser_valid && first_t < 0) first_t = t;
      if (poke && t == 5) begin
        start      = 1'b1;
        start_addr = ~a7;
        count      = 8'd1;
      end else begin
        start = 1'b0;
      end
      ser_ready = ($urandom_range(0, 99) < pct);
      if (ser_valid && ser_ready) begin
        w = rom_mem[(addr + nbits / 20) % 128];
        check("bit", ser_data, w[nbits % 20]);
        check("mark", word_mark, (nbits % 20 == 19) ? 1 : 0);
        nbits++;
      end
      pv = ser_valid;
      pr = ser_ready;
      pd = ser_data;
      pm = word_mark;
      step();
      t++;
      if (pv && !pr) begin
        check("stall_valid", ser_valid, 1);
        check("stall_data", ser_data, pd);
        check("stall_mark", word_mark, pm);
      end
      if (done) done_seen = 1'b1;
    end
    start = 1'b0;
    check("done_seen", done_seen, 1);
    check("bit_total", nbits, 20 * cnt);
    check("first_valid", first_t, 2);
    check("end_busy", busy, 0);
    check("end_valid", ser_valid, 0);
    check("end_mark", word_mark, 0);
    if (pct == 100) check("latency", t, 2 + 20 * cnt);
    step();
    check("done_pulse", done, 0);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) rom_mem[i] = 20'($urandom());
    rom_mem[5] = 20'h8_0001;
    rst_n      = 1'b1;
    start      = 1'b0;
    start_addr = '0;
    count      = '0;
    abort      = 1'b0;
    ser_ready  = 1'b1;

    // Reset values
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_addr", rom_addr, 0);
    check("rst_data", ser_data, 0);
    check("rst_valid", ser_valid, 0);
    check("rst_mark", word_mark, 0);
    #2 rst_n = 1'b1;
    step();

    // count 0: lone done pulse, busy never rises
    start_addr = 7'd9;
    count      = 8'd0;
    start      = 1'b1;
    step();
    start = 1'b0;
    check("zero_done", done, 1);
    check("zero_busy", busy, 0);
    step();
    check("zero_done_end", done, 0);
    check("zero_busy_end", busy, 0);

    run(5, 1, 100, -1, 1'b0);     // 20'h80001
    run(127, 2, 100, -1, 1'b0);   // address wrap
    run(0, 128, 100, -1, 1'b0);   // full sweep
    run(20, 3, 100, -1, 1'b0);
    run(20, 3, 50, -1, 1'b0);     // same words under random stalls
    run(60, 3, 100, 27, 1'b0);    // abort on bit 7 of word 2
    run(10, 1, 100, -1, 1'b0);
    run(90, 2, 100, -1, 1'b1);    // stray start while busy

    // Reset mid-word
    start_addr = 7'd50;
    count      = 8'd2;
    start      = 1'b1;
    step();
    start     = 1'b0;
    ser_ready = 1'b1;
    repeat (30) step();
    check("mid_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_addr", rom_addr, 0);
    check("arst_data", ser_data, 0);
    check("arst_valid", ser_valid, 0);
    check("arst_mark", word_mark, 0);
    #10 rst_n = 1'b1;
    repeat (5) step();
    check("post_rst_idle", {busy, ser_valid}, 0);

    run(33, 1, 100, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
